requantizer: RTL and testbench

Narrows 12-bit accumulator results from the adder/MAC datapath back to 8-bit activations for the next layer. It is the width-reducing counterpart of the accumulate path: 8-bit operands are widened to 12 bits going in, and this block brings them back down to 8 bits.
- Each value is right-shifted with round-half-up, then saturated to 8 bits unsigned.
- The datapath is a 2-stage valid/ready pipeline with backpressure.
- A saturating counter records how many results were clipped, for calibration.

---
 rtl/quant_pkg.sv | 43 ++++
 rtl/requantizer_if.sv | 28 ++
 rtl/sat_counter.sv | 33 +++
 rtl/requantizer.sv | 96 +++++++++
 tb/tb_requantizer.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/quant_pkg.sv
// Shared quantisation types and arithmetic used by the accumulate, requantize and pooling blocks.
// Widths here fix the shape of round_shift_sat; blocks importing it keep their widths equal to these.
package quant_pkg;

  localparam int ACC_W   = 12;
  localparam int ACT_W   = 8;
  localparam int SHIFT_W = 4;

  // Largest activation, zero-extended to the rounded-sum width.
  localparam logic [ACC_W:0] ACT_MAX_W = {{(ACC_W + 1 - ACT_W){1'b0}}, {ACT_W{1'b1}}};

  typedef struct packed {
    logic             sat;
    logic [ACT_W-1:0] data;
  } act_t;

  // acc + half an output LSB; one extra bit so 4095 + 2048 cannot wrap.
  function automatic logic [ACC_W:0] round_add(input logic [ACC_W-1:0]   acc,
                                               input logic [SHIFT_W-1:0] shift);
    logic [ACC_W:0] rc;
    rc = '0;
    if (shift != '0) begin
      rc = {{ACC_W{1'b0}}, 1'b1} << (shift - SHIFT_W'(1));
    end
    return {1'b0, acc} + rc;
  endfunction

  function automatic act_t round_shift_sat(input logic [ACC_W:0]   sum,
                                           input logic [SHIFT_W-1:0] shift);
    logic [ACC_W:0] r;
    act_t           res;
    r = (32'(shift) > ACC_W) ? '0 : (sum >> shift);
    if (r > ACT_MAX_W) begin
      res.sat  = 1'b1;
      res.data = '1;
    end else begin
      res.sat  = 1'b0;
      res.data = r[ACT_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/requantizer_if.sv
// Accumulator-in / activation-out stream bundle for the requantizer.
// Handshake: a word moves on a rising edge where valid and ready are both 1; valid never waits on ready.
interface requantizer_if #(
  parameter int IN_W    = quant_pkg::ACC_W,
  parameter int OUT_W   = quant_pkg::ACT_W,
  parameter int SHIFT_W = quant_pkg::SHIFT_W
);

  logic [IN_W-1:0]    in_data;
  logic [SHIFT_W-1:0] in_shift;
  logic               in_valid;
  logic               in_ready;
  logic [OUT_W-1:0]   out_data;
  logic               out_sat;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output in_data, in_shift, in_valid, out_ready,
    input  in_ready, out_data, out_sat, out_valid
  );

  modport slave (
    input  in_data, in_shift, in_valid, out_ready,
    output in_ready, out_data, out_sat, out_valid
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/requantizer.sv
// Narrows 12-bit accumulator values to 8-bit activations: round-half-up shift, unsigned saturate,
// in a 2-stage valid/ready pipeline, with a saturating count of clipped results delivered.
module requantizer #(
  parameter int IN_W    = quant_pkg::ACC_W,
  parameter int OUT_W   = quant_pkg::ACT_W,
  parameter int SHIFT_W = quant_pkg::SHIFT_W,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  requantizer_if.slave     bus,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] sat_count
);

  import quant_pkg::*;

  logic               s1_valid_q, s1_valid_d;
  logic [IN_W:0]      s1_sum_q, s1_sum_d;
  logic [SHIFT_W-1:0] s1_shift_q, s1_shift_d;
  logic               s2_valid_q, s2_valid_d;
  logic [OUT_W-1:0]   out_data_q, out_data_d;
  logic               out_sat_q, out_sat_d;

  logic adv1, adv2;
  logic sat_inc;
  act_t s2_res;

  // Ready ripples back combinationally so a full pipe still moves one word per cycle.
  assign adv2         = !s2_valid_q || bus.out_ready;
  assign adv1         = !s1_valid_q || adv2;
  assign bus.in_ready = rst_n && adv1;

  assign s2_res = round_shift_sat(s1_sum_q, s1_shift_q);

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sum_d   = s1_sum_q;
    s1_shift_d = s1_shift_q;
    s2_valid_d = s2_valid_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;

    if (adv1) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_sum_d   = round_add(bus.in_data, bus.in_shift);
        s1_shift_d = bus.in_shift;
      end
    end

    // Output payload only changes when a new word lands, so it holds through stalls and bubbles.
    if (adv2) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = s2_res.data;
        out_sat_d  = s2_res.sat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sum_q   <= '0;
      s1_shift_q <= '0;
      s2_valid_q <= 1'b0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sum_q   <= s1_sum_d;
      s1_shift_q <= s1_shift_d;
      s2_valid_q <= s2_valid_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;

  assign sat_inc = s2_valid_q && bus.out_ready && out_sat_q;

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_sat_count (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (sat_inc),
    .clr  (clr_stats),
    .count(sat_count)
  );

endmodule

// File: tb/tb_requantizer.sv
// Directed bench for requantizer: arithmetic reference model + scoreboard queue checked every cycle,
// plus literal expectations per scenario.
module tb_requantizer;

  localparam int IN_W    = 12;
  localparam int OUT_W   = 8;
  localparam int SHIFT_W = 4;
  localparam int CNT_W   = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int ACT_MAX = (1 << OUT_W) - 1;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic             clr_stats = 1'b0;
  logic [CNT_W-1:0] sat_count;

  requantizer_if #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W)) bus ();

  requantizer #(
    .IN_W   (IN_W),
    .OUT_W  (OUT_W),
    .SHIFT_W(SHIFT_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .clr_stats(clr_stats),
    .sat_count(sat_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;

  logic [OUT_W:0] exp_q[$];
  int             t_q[$];
  int             log_data[$];
  int             log_sat[$];
  int             log_cyc[$];
  int             log_lat[$];
  int             cnt_model = 0;
  logic           stall_hold = 1'b0;
  logic [OUT_W-1:0] held_data;
  logic           held_sat;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference: add half an LSB, shift, clip to the activation range.
  function automatic logic [OUT_W:0] model(input int v, input int sh);
    int r;
    r = v + ((sh == 0) ? 0 : (1 << (sh - 1)));
    r = r >> sh;
    if (r > ACT_MAX) return {1'b1, OUT_W'(ACT_MAX)};
    return {1'b0, OUT_W'(r)};
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin : mon
    logic [OUT_W:0] e;
    int             t;
    logic           sat_hs;
    sat_hs = 1'b0;
    if (!rst_n) begin
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_out_sat", bus.out_sat, 0);
      chk("rst_sat_count", sat_count, 0);
      exp_q.delete();
      t_q.delete();
      cnt_model  = 0;
      stall_hold = 1'b0;
    end else begin
      chk("sat_count", sat_count, cnt_model);
      if (stall_hold) begin
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_data", bus.out_data, held_data);
        chk("stall_sat", bus.out_sat, held_sat);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_queue", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          t = t_q.pop_front();
          chk("out_data", bus.out_data, e[OUT_W-1:0]);
          chk("out_sat", bus.out_sat, e[OUT_W]);
          chk("latency_min", ((cyc - t) >= 2) ? 1 : 0, 1);
          sat_hs = e[OUT_W];
          log_data.push_back(int'(bus.out_data));
          log_sat.push_back(int'(bus.out_sat));
          log_cyc.push_back(cyc);
          log_lat.push_back(cyc - t);
        end
      end
      stall_hold = bus.out_valid && !bus.out_ready;
      held_data  = bus.out_data;
      held_sat   = bus.out_sat;
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(int'(bus.in_data), int'(bus.in_shift)));
        t_q.push_back(cyc);
      end
      if (clr_stats) cnt_model = 0;
      else if (sat_hs && cnt_model < CNT_MAX) cnt_model++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int v, input int sh);
    int b;
    b = 0;
    bus.in_data  = IN_W'(v);
    bus.in_shift = SHIFT_W'(sh);
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && b < 50) begin
      @(negedge clk);
      b++;
    end
    if (!bus.in_ready) chk("send_timeout_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 200) begin
      @(negedge clk);
      b++;
    end
    @(posedge clk);
    #1;
    chk("drain_queue_empty", exp_q.size(), 0);
  endtask

  task automatic clear_log();
    log_data.delete();
    log_sat.delete();
    log_cyc.delete();
    log_lat.delete();
  endtask

  task automatic check_log(input string name, input int n, input int ed[6], input int es[6]);
    chk({name, "_count"}, log_data.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < log_data.size()) begin
        chk({name, "_data"}, log_data[i], ed[i]);
        chk({name, "_sat"}, log_sat[i], es[i]);
      end
    end
  endtask

  task automatic check_back2back(input string name);
    for (int i = 1; i < log_cyc.size(); i++) begin
      chk({name, "_gap"}, log_cyc[i] - log_cyc[i-1], 1);
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_shift  = '0;
    bus.out_ready = 1'b1;
    #2;
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_in_ready", bus.in_ready, 0);
    chk("reset_sat_count", sat_count, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("post_reset_in_ready", bus.in_ready, 1);

    // Rounding at shift 2: 12>>2=3, 11>>2=2, 8>>2=2.
    clear_log();
    send(10, 2);
    send(9, 2);
    send(6, 2);
    bus.in_valid = 1'b0;
    drain();
    check_log("round", 3, '{3, 2, 2, 0, 0, 0}, '{0, 0, 0, 0, 0, 0});
    if (log_lat.size() > 0) chk("round_first_latency", log_lat[0], 2);
    check_back2back("round");

    // Saturation boundary.
    clear_log();
    send(4087, 4);
    send(4095, 4);
    send(300, 0);
    send(4095, 13);
    bus.in_valid = 1'b0;
    drain();
    check_log("sat", 4, '{255, 255, 255, 0, 0, 0}, '{0, 1, 1, 0, 0, 0});
    chk("sat_count_after_boundary", sat_count, 2);

    // Backpressure: four words offered while the sink stalls for four cycles.
    clear_log();
    bus.out_ready = 1'b0;
    fork
      begin
        send(1, 0);
        send(2, 0);
        send(3, 0);
        send(4, 0);
        bus.in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready_low", bus.in_ready, 0);
        chk("bp_accepted", exp_q.size(), 2);
        chk("bp_out_valid", bus.out_valid, 1);
        chk("bp_out_data_hold", bus.out_data, 1);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();
    check_log("bp", 4, '{1, 2, 3, 4, 0, 0}, '{0, 0, 0, 0, 0, 0});
    check_back2back("bp");

    // Full rate, mixed shifts: 13, 714>>1 (357->255 sat), 1413+2>>2=353->255 sat,
    // 2113+4>>3=264->255 sat, 2813+8>>4=176, 3513 -> 255 sat.
    clear_log();
    for (int i = 0; i < 6; i++) send(i * 700 + 13, i % 5);
    bus.in_valid = 1'b0;
    drain();
    check_log("full", 6, '{13, 255, 255, 255, 176, 255}, '{0, 1, 1, 1, 0, 1});
    if (log_lat.size() > 0) chk("full_first_latency", log_lat[0], 2);
    check_back2back("full");

    // Counter: clear, count two, then clear on the same edge as a saturated handshake.
    clr_stats = 1'b1;
    @(posedge clk);
    #1;
    clr_stats = 1'b0;
    chk("cnt_cleared", sat_count, 0);
    send(300, 0);
    send(300, 0);
    bus.in_valid = 1'b0;
    drain();
    chk("cnt_two", sat_count, 2);
    send(300, 0);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    clr_stats = 1'b1;
    chk("clr_edge_out_valid", bus.out_valid, 1);
    @(posedge clk);
    #1;
    clr_stats = 1'b0;
    chk("clr_wins", sat_count, 0);
    drain();

    // Counter saturation: 2^16 + 2 clipped results.
    for (int i = 0; i < CNT_MAX + 3; i++) send(300, 0);
    bus.in_valid = 1'b0;
    drain();
    chk("cnt_sticks_at_max", sat_count, CNT_MAX);

    // Async reset with both stages full and the sink stalled.
    clear_log();
    bus.out_ready = 1'b0;
    send(5, 0);
    send(6, 0);
    bus.in_valid = 1'b0;
    chk("full_in_ready_low", bus.in_ready, 0);
    chk("full_out_valid", bus.out_valid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", bus.out_valid, 0);
    chk("async_in_ready", bus.in_ready, 0);
    chk("async_sat_count", sat_count, 0);
    chk("async_out_data", bus.out_data, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("no_emit_after_reset", log_data.size(), 0);
    chk("idle_out_valid", bus.out_valid, 0);
    send(7, 1);
    bus.in_valid = 1'b0;
    drain();
    check_log("after_reset", 1, '{4, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
